btn_debounce_sel: RTL and testbench

- Clocked front-end that conditions raw board push-buttons into clean control signals.
- Drives the 4-bit select bus (a_mxm) of the downstream 2:1 multiplexer bank, one bit per button.
- Per channel: synchronises the raw pin, debounces it with a counter FSM, emits one-cycle press/release pulses, and toggles a select bit on each press.
- Channels are fully independent; there is no cross-channel state.

---
 rtl/btn_debounce_sel_pkg.sv | 22 ++
 rtl/btn_debounce_sel_ch.sv | 122 ++++++++++++
 rtl/btn_debounce_sel.sv | 36 +++
 tb/tb_btn_debounce_sel.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/btn_debounce_sel_pkg.sv
// Shared definitions for the push-button debounce / select front-end:
// FSM state encodings, board-clock defaults and a pin-level helper.
package btn_debounce_sel_pkg;

    // Per-channel debounce FSM states (2-bit encoding).
    typedef enum logic [1:0] {
        REL_STABLE = 2'd0,
        WAIT_PRESS = 2'd1,
        PRS_STABLE = 2'd2,
        WAIT_REL   = 2'd3
    } btn_state_e;

    // 1 ms of stable input at the 50 MHz board clock.
    localparam int BTN_DEBOUNCE_CYCLES_DFLT = 50000;
    localparam int BTN_CNT_W_DFLT           = 16;

    // Raw pin level seen when the button is NOT pressed.
    function automatic logic released_pin_level(input bit active_low);
        return logic'(active_low);
    endfunction

endpackage

// File: rtl/btn_debounce_sel_ch.sv
// Single button channel: two-flop synchroniser, polarity normalisation,
// counter-based debounce FSM, press/release pulses and a toggle-per-press
// select bit. All outputs are registered.
module btn_debounce_ch
    import btn_debounce_sel_pkg::*;
#(
    parameter int CNT_W           = BTN_CNT_W_DFLT,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DFLT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic sel_out,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    // Reject parameter sets where the terminal count is too small or does
    // not fit in the counter.
    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_param
        $error("btn_debounce_ch: DEBOUNCE_CYCLES=%0d invalid for CNT_W=%0d",
               DEBOUNCE_CYCLES, CNT_W);
    end

    localparam logic             REL_PIN  = released_pin_level(BTN_ACTIVE_LOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             s;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; resets to the released pin level so a held
    // button is seen as a fresh press after reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and the chain really is two stages deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= REL_PIN;
            sync2 <= REL_PIN;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // s = 1 means pressed, regardless of board polarity.
    assign s = sync2 ^ BTN_ACTIVE_LOW;

    // Debounce FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= REL_STABLE;
            cnt           <= '0;
            sel_out       <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                REL_STABLE: begin
                    if (s) begin
                        state <= WAIT_PRESS;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!s) begin
                        // Bounce: full restart, not a resume.
                        state <= REL_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRS_STABLE;
                        busy        <= 1'b0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        sel_out     <= ~sel_out;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRS_STABLE: begin
                    if (!s) begin
                        state <= WAIT_REL;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (s) begin
                        state <= PRS_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= REL_STABLE;
                        busy          <= 1'b0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= REL_STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_sel.sv
// Push-button front-end driving the mux bank select bus (a_mxm).
// Wiring only: one independent btn_debounce_ch per button.
module btn_debounce_sel
    import btn_debounce_sel_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int CNT_W           = BTN_CNT_W_DFLT,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DFLT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] sel_out,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] busy
);

    btn_debounce_ch #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_ch [N_CH-1:0] (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .sel_out       (sel_out),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

endmodule

// File: tb/tb_btn_debounce_sel.sv
// Directed bench for btn_debounce_sel with DEBOUNCE_CYCLES=4, active-low pins.
// A pin change driven before edge 1 is accepted on edge 7.
module tb_btn_debounce_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] sel_out;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] busy;

    int vectors    = 0;
    int miscompares = 0;

    btn_debounce_sel #(
        .N_CH            (4),
        .CNT_W           (16),
        .DEBOUNCE_CYCLES (4),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .sel_out       (sel_out),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   sel_out,       4'b0000);
        check({tag, "_level"}, btn_level,     4'b0000);
        check({tag, "_press"}, press_pulse,   4'b0000);
        check({tag, "_rel"},   release_pulse, 4'b0000);
        check({tag, "_busy"},  busy,          4'b0000);
    endtask

    // Clean press (pressed=1) or release of the channels in mask; checks
    // pulses and busy on every edge, sel/level on the accepting edge 7.
    task automatic clean_change(input string tag, input logic [3:0] mask,
                                input logic pressed, input logic [3:0] exp_sel,
                                input logic [3:0] exp_level);
        btn_raw = pressed ? (btn_raw & ~mask) : (btn_raw | mask);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("%s_press_e%0d", tag, k), press_pulse,
                  (pressed && k == 7) ? mask : 4'b0000);
            check($sformatf("%s_rel_e%0d", tag, k), release_pulse,
                  (!pressed && k == 7) ? mask : 4'b0000);
            check($sformatf("%s_busy_e%0d", tag, k), busy,
                  (k >= 3 && k <= 6) ? mask : 4'b0000);
            if (k == 7) begin
                check({tag, "_sel"},   sel_out,   exp_sel);
                check({tag, "_level"}, btn_level, exp_level);
            end
        end
    endtask

    initial begin
        // Reset with all buttons released.
        rst     = 1'b1;
        btn_raw = 4'b1111;
        step();
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("idle");

        // Clean press / release on channel 0.
        clean_change("ch0_press", 4'b0001, 1'b1, 4'b0001, 4'b0001);
        clean_change("ch0_rel",   4'b0001, 1'b0, 4'b0001, 4'b0000);

        // Bounce on channel 1: low 3, high 1, then low; press on edge 11.
        for (int k = 1; k <= 12; k++) begin
            btn_raw[1] = (k == 4) ? 1'b1 : 1'b0;
            step();
            check($sformatf("bounce_press_e%0d", k), press_pulse,
                  (k == 11) ? 4'b0010 : 4'b0000);
            if (k == 10) check("bounce_level_pre", btn_level, 4'b0000);
            if (k == 11) begin
                check("bounce_sel",   sel_out,   4'b0011);
                check("bounce_level", btn_level, 4'b0010);
            end
        end
        clean_change("ch1_rel", 4'b0010, 1'b0, 4'b0011, 4'b0000);

        // Two 2-cycle glitches on channel 1: nothing must be accepted.
        for (int k = 1; k <= 12; k++) begin
            btn_raw[1] = (k == 1 || k == 2 || k == 5 || k == 6) ? 1'b0 : 1'b1;
            step();
            check($sformatf("glitch_press_e%0d", k), press_pulse, 4'b0000);
            check($sformatf("glitch_level_e%0d", k), btn_level, 4'b0000);
        end
        check("glitch_sel", sel_out, 4'b0011);

        // Channel 2 pressed and released twice: sel_out[2] 0 -> 1 -> 0.
        clean_change("ch2_p1", 4'b0100, 1'b1, 4'b0111, 4'b0100);
        clean_change("ch2_r1", 4'b0100, 1'b0, 4'b0111, 4'b0000);
        clean_change("ch2_p2", 4'b0100, 1'b1, 4'b0011, 4'b0100);
        clean_change("ch2_r2", 4'b0100, 1'b0, 4'b0011, 4'b0000);

        // Reset back to a clean sel bus, then simultaneous press on 0 and 3.
        rst = 1'b1;
        step();
        check_all_zero("reset2");
        rst = 1'b0;
        clean_change("sim_press", 4'b1001, 1'b1, 4'b1001, 4'b1001);
        clean_change("sim_rel",   4'b1001, 1'b0, 4'b1001, 4'b0000);

        // Reset mid-count with channel 0 held through reset release.
        rst = 1'b1;
        step();
        check_all_zero("reset3");
        rst = 1'b0;
        btn_raw[0] = 1'b0;
        step();
        step();
        step();
        check("midcnt_busy", busy, 4'b0001);
        rst = 1'b1;
        step();
        check_all_zero("midcnt_rst");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("midcnt_press_e%0d", k), press_pulse,
                  (k == 7) ? 4'b0001 : 4'b0000);
            if (k == 7) check("midcnt_sel", sel_out, 4'b0001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
